// File: rtl/stage_mem.sv
// Memory-access pipeline stage: issues one data-bus transaction per
// load/store and forwards a registered writeback packet downstream.
module stage_mem #(
   parameter int BUS_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       memOp_in,
   input  logic [5:0]       wdOp_in,
   input  logic [BUS_W-1:0] rs2Data_in,
   input  logic [BUS_W-1:0] exResult_in,
   output logic             stall_out,
   output logic             memErr_out,
   output logic             dmemReq_out,
   output logic             dmemWe_out,
   output logic [BUS_W-1:0] dmemAddr_out,
   output logic [BUS_W-1:0] dmemWdata_out,
   output logic [3:0]       dmemBe_out,
   input  logic             dmemAck_in,
   input  logic [BUS_W-1:0] dmemRdata_in,
   output logic [5:0]       wdOp_out,
   output logic [BUS_W-1:0] wbData_out
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t           state;
   logic [5:0]       lat_wd;
   logic [1:0]       lat_off;
   logic [1:0]       lat_size;
   logic             lat_uns;

   logic             mem_en;
   logic             mem_we;
   logic             mem_uns;
   logic [1:0]       mem_size;
   logic [1:0]       off;
   logic             legal;
   logic [3:0]       be_next;
   logic [BUS_W-1:0] wdata_next;
   logic [BUS_W-1:0] lane;
   logic [BUS_W-1:0] load_data;
   logic             ext;

   assign mem_en   = memOp_in[0];
   assign mem_we   = memOp_in[1];
   assign mem_size = memOp_in[3:2];
   assign mem_uns  = memOp_in[4];
   assign off      = exResult_in[1:0];

   always_comb begin
      legal = 1'b0;
      unique case (mem_size)
         2'b00:   legal = 1'b1;
         2'b01:   legal = !off[0];
         2'b10:   legal = (off == 2'b00);
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      be_next    = 4'b1111;
      wdata_next = rs2Data_in;
      unique case (mem_size)
         2'b00: begin
            be_next    = 4'b0001 << off;
            wdata_next = {4{rs2Data_in[7:0]}};
         end
         2'b01: begin
            be_next    = 4'b0011 << off;
            wdata_next = {2{rs2Data_in[15:0]}};
         end
         default: ;
      endcase
   end

   // Shift the addressed lane down to bit 0 before extension.
   assign lane = dmemRdata_in >> {lat_off, 3'b000};

   always_comb begin
      load_data = lane;
      ext       = 1'b0;
      unique case (lat_size)
         2'b00: begin
            ext       = !lat_uns & lane[7];
            load_data = {{(BUS_W-8){ext}}, lane[7:0]};
         end
         2'b01: begin
            ext       = !lat_uns & lane[15];
            load_data = {{(BUS_W-16){ext}}, lane[15:0]};
         end
         default: ;
      endcase
   end

   assign stall_out = (state == IDLE && mem_en && legal)
                   || (state == WAIT && !dmemAck_in);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         lat_wd        <= '0;
         lat_off       <= '0;
         lat_size      <= '0;
         lat_uns       <= 1'b0;
         memErr_out    <= 1'b0;
         dmemReq_out   <= 1'b0;
         dmemWe_out    <= 1'b0;
         dmemAddr_out  <= '0;
         dmemWdata_out <= '0;
         dmemBe_out    <= '0;
         wdOp_out      <= '0;
         wbData_out    <= '0;
      end else begin
         memErr_out <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!mem_en) begin
                  wdOp_out   <= wdOp_in;
                  wbData_out <= exResult_in;
               end else if (!legal) begin
                  memErr_out <= 1'b1;
                  wdOp_out   <= '0;
               end else begin
                  lat_wd        <= wdOp_in;
                  lat_off       <= off;
                  lat_size      <= mem_size;
                  lat_uns       <= mem_uns;
                  dmemReq_out   <= 1'b1;
                  dmemWe_out    <= mem_we;
                  dmemAddr_out  <= {exResult_in[BUS_W-1:2], 2'b00};
                  dmemBe_out    <= be_next;
                  dmemWdata_out <= wdata_next;
                  wdOp_out      <= '0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               wdOp_out <= '0;
               if (dmemAck_in) begin
                  dmemReq_out <= 1'b0;
                  state       <= IDLE;
                  if (!dmemWe_out) begin
                     wdOp_out   <= lat_wd;
                     wbData_out <= load_data;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: directed loads/stores, errors and
// reset abort; writeback packets checked by an independent monitor.
module tb_stage_mem;

   typedef struct packed {
      logic [5:0]  wd;
      logic [31:0] data;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  memOp = '0;
   logic [5:0]  wdOp = '0;
   logic [31:0] rs2Data = '0;
   logic [31:0] exResult = '0;
   logic        stall_out;
   logic        memErr_out;
   logic        dmemReq_out;
   logic        dmemWe_out;
   logic [31:0] dmemAddr_out;
   logic [31:0] dmemWdata_out;
   logic [3:0]  dmemBe_out;
   logic        dmemAck = 1'b0;
   logic [31:0] dmemRdata = '0;
   logic [5:0]  wdOp_out;
   logic [31:0] wbData_out;

   wb_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   stage_mem #(.BUS_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .memOp_in      (memOp),
      .wdOp_in       (wdOp),
      .rs2Data_in    (rs2Data),
      .exResult_in   (exResult),
      .stall_out     (stall_out),
      .memErr_out    (memErr_out),
      .dmemReq_out   (dmemReq_out),
      .dmemWe_out    (dmemWe_out),
      .dmemAddr_out  (dmemAddr_out),
      .dmemWdata_out (dmemWdata_out),
      .dmemBe_out    (dmemBe_out),
      .dmemAck_in    (dmemAck),
      .dmemRdata_in  (dmemRdata),
      .wdOp_out      (wdOp_out),
      .wbData_out    (wbData_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", nm, act, req);
      end
   endtask

   // Writeback monitor: every non-bubble packet must match the queue head.
   always @(negedge clk) begin
      wb_t e;
      if (rst && wdOp_out != 6'd0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_wb", {26'd0, wdOp_out}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wb_op", {26'd0, wdOp_out}, {26'd0, e.wd});
            chk("wb_data", wbData_out, e.data);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      memOp    = '0;
      wdOp     = '0;
      rs2Data  = '0;
      exResult = '0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_req"}, {31'd0, dmemReq_out}, 32'd0);
      chk({nm, "_we"}, {31'd0, dmemWe_out}, 32'd0);
      chk({nm, "_addr"}, dmemAddr_out, 32'd0);
      chk({nm, "_wdata"}, dmemWdata_out, 32'd0);
      chk({nm, "_be"}, {28'd0, dmemBe_out}, 32'd0);
      chk({nm, "_wdop"}, {26'd0, wdOp_out}, 32'd0);
      chk({nm, "_wbdata"}, wbData_out, 32'd0);
      chk({nm, "_err"}, {31'd0, memErr_out}, 32'd0);
      chk({nm, "_stall"}, {31'd0, stall_out}, 32'd0);
   endtask

   task automatic txn(input string nm, input logic [4:0] op,
                      input logic [5:0] wd, input logic [31:0] rs2,
                      input logic [31:0] addr, input int waits,
                      input logic [31:0] rdata, input logic r_we,
                      input logic [31:0] r_addr, input logic [31:0] r_wdata,
                      input logic [3:0] r_be, input int r_stalls);
      int stalls;
      stalls   = 0;
      memOp    = op;
      wdOp     = wd;
      rs2Data  = rs2;
      exResult = addr;
      @(negedge clk);
      if (stall_out) stalls++;
      step();
      idle();
      for (int i = 0; i <= waits; i++) begin
         if (i == waits) begin
            dmemAck   = 1'b1;
            dmemRdata = rdata;
         end
         @(negedge clk);
         if (stall_out) stalls++;
         chk({nm, "_req"}, {31'd0, dmemReq_out}, 32'd1);
         chk({nm, "_addr"}, dmemAddr_out, r_addr);
         if (i == 0) begin
            chk({nm, "_we"}, {31'd0, dmemWe_out}, {31'd0, r_we});
            chk({nm, "_be"}, {28'd0, dmemBe_out}, {28'd0, r_be});
            chk({nm, "_wdata"}, dmemWdata_out, r_wdata);
         end
         step();
      end
      dmemAck   = 1'b0;
      dmemRdata = '0;
      @(negedge clk);
      chk({nm, "_req_fall"}, {31'd0, dmemReq_out}, 32'd0);
      chk({nm, "_stalls"}, stalls, r_stalls);
   endtask

   task automatic bad_op(input string nm, input logic [4:0] op,
                         input logic [31:0] addr);
      memOp    = op;
      wdOp     = 6'b000101;
      exResult = addr;
      @(negedge clk);
      chk({nm, "_stall"}, {31'd0, stall_out}, 32'd0);
      step();
      idle();
      @(negedge clk);
      chk({nm, "_err"}, {31'd0, memErr_out}, 32'd1);
      chk({nm, "_req"}, {31'd0, dmemReq_out}, 32'd0);
      chk({nm, "_wdop"}, {26'd0, wdOp_out}, 32'd0);
      step();
      @(negedge clk);
      chk({nm, "_err_end"}, {31'd0, memErr_out}, 32'd0);
   endtask

   initial begin
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk);
      #1 rst = 1'b1;

      memOp    = 5'b00000;
      wdOp     = 6'b001011;
      exResult = 32'h12345678;
      exp_q.push_back(wb_t'({6'b001011, 32'h12345678}));
      @(negedge clk);
      chk("alu_stall", {31'd0, stall_out}, 32'd0);
      step();
      idle();
      @(negedge clk);
      chk("alu_stall2", {31'd0, stall_out}, 32'd0);

      exp_q.push_back(wb_t'({6'b001111, 32'hFFFFFF80}));
      txn("lb", 5'b00001, 6'b001111, 32'h0, 32'h00001003, 3,
          32'h80FFFFFF, 1'b0, 32'h00001000, 32'h0, 4'b1000, 4);

      exp_q.push_back(wb_t'({6'b000011, 32'h0000BEEF}));
      txn("lhu", 5'b10101, 6'b000011, 32'h0, 32'h00000002, 0,
          32'hBEEF1234, 1'b0, 32'h00000000, 32'h0, 4'b1100, 1);

      txn("sh", 5'b00111, 6'b000011, 32'hCAFEA55A, 32'h00000006, 0,
          32'h0, 1'b1, 32'h00000004, 32'hA55AA55A, 4'b1100, 1);
      chk("sh_wdop", {26'd0, wdOp_out}, 32'd0);

      exp_q.push_back(wb_t'({6'b010001, 32'hFFFF8001}));
      txn("lh", 5'b00101, 6'b010001, 32'h0, 32'h00000000, 1,
          32'h00018001, 1'b0, 32'h00000000, 32'h0, 4'b0011, 2);

      exp_q.push_back(wb_t'({6'b000111, 32'h00000034}));
      txn("lbu", 5'b10001, 6'b000111, 32'h0, 32'h00000101, 2,
          32'h12AB3456, 1'b0, 32'h00000100, 32'h0, 4'b0010, 3);

      exp_q.push_back(wb_t'({6'b111111, 32'hDEADBEEF}));
      txn("lw", 5'b01001, 6'b111111, 32'h0, 32'h00000010, 0,
          32'hDEADBEEF, 1'b0, 32'h00000010, 32'h0, 4'b1111, 1);

      txn("sb", 5'b00011, 6'b000001, 32'h000000C3, 32'h00000007, 0,
          32'h0, 1'b1, 32'h00000004, 32'hC3C3C3C3, 4'b1000, 1);
      chk("sb_wdop", {26'd0, wdOp_out}, 32'd0);

      bad_op("mis_w", 5'b01001, 32'h00000002);
      bad_op("mis_h", 5'b00101, 32'h00000003);
      bad_op("rsv", 5'b01101, 32'h00000000);

      memOp    = 5'b01001;
      wdOp     = 6'b000111;
      exResult = 32'h00000020;
      @(negedge clk);
      step();
      idle();
      @(negedge clk);
      chk("rst_mid_req", {31'd0, dmemReq_out}, 32'd1);
      #1 rst = 1'b0;
      #1 chk_zero("rst_mid");
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      dmemAck   = 1'b1;
      dmemRdata = 32'h00000055;
      @(negedge clk);
      chk("late_ack_stall", {31'd0, stall_out}, 32'd0);
      step();
      dmemAck   = 1'b0;
      dmemRdata = '0;
      @(negedge clk);
      chk("late_ack_wdop", {26'd0, wdOp_out}, 32'd0);
      chk("late_ack_req", {31'd0, dmemReq_out}, 32'd0);

      step();
      @(negedge clk);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stage_mem.md
# stage_mem

Memory-access pipeline stage sitting directly downstream of the execute stage. It consumes the registered memory opcode, writeback opcode, store data and execute result. It then runs a registered request/acknowledge transaction on the data-memory bus for loads and stores, and hands a registered writeback packet to the writeback stage. While a bus access is outstanding it asserts a stall back to the front of the pipeline.

## Interface
- BUS_W, 32: datapath and bus width; byte lanes = BUS_W/8 (only 32 is supported)
- clk  input  1  stage clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- memOp_in  input  5  [0] memEn, [1] write(1)/read(0), [3:2] size 00 byte / 01 half / 10 word / 11 reserved, [4] unsigned load
- wdOp_in  input  6  [0] wbEn, [5:1] rd index; passed to writeback
- rs2Data_in  input  BUS_W  store data, unaligned (low bits)
- exResult_in  input  BUS_W  ALU result; memory address when memEn=1
- stall_out  output  1  pipeline hold request (combinational)
- memErr_out  output  1  one-cycle pulse: misaligned or reserved-size access dropped
- dmemReq_out  output  1  bus request, registered
- dmemWe_out  output  1  bus write enable, registered
- dmemAddr_out  output  BUS_W  word-aligned address (low 2 bits 0)
- dmemWdata_out  output  BUS_W  lane-aligned store data
- dmemBe_out  output  4  byte enables
- dmemAck_in  input  1  bus completion, one cycle
- dmemRdata_in  input  BUS_W  read word, valid when dmemAck_in=1
- wdOp_out  output  6  registered writeback opcode; 0 = bubble
- wbData_out  output  BUS_W  registered writeback data

## Operation
- FSM states: IDLE, WAIT.
- IDLE, memEn=0: wbData_out <= exResult_in, wdOp_out <= wdOp_in; stays IDLE.
- IDLE, memEn=1, size reserved or misaligned (half with addr[0]=1, word with addr[1:0]!=0): no bus access, memErr_out pulses next cycle, wdOp_out <= 0; stays IDLE.
- IDLE, memEn=1, legal: latch address, rd, size and sign bits into internal registers. dmemReq_out <= 1; dmemWe_out <= write; dmemAddr_out <= {addr[BUS_W-1:2],2'b00}. Byte enables: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111. dmemWdata_out <= byte replicated 4×, half replicated 2×, or the word. wdOp_out <= 0. Go to WAIT.
- WAIT, ack=0: bus outputs held stable, wdOp_out <= 0.
- WAIT, ack=1: dmemReq_out <= 0, go to IDLE. Load: wdOp_out <= latched wdOp; wbData_out <= selected lane, zero-extended if unsigned, else sign-extended. Store: wdOp_out <= 0.
- stall_out = (IDLE & memEn & legal) | (WAIT & !dmemAck_in). Upstream advances in the ack cycle, and the next instruction is sampled in the following IDLE cycle.
- dmemAck_in while IDLE is ignored.

## Timing
- Reset (asynchronous, rst=0): state IDLE; every output register is 0. That covers dmemReq_out, dmemWe_out, dmemAddr_out, dmemWdata_out, dmemBe_out, wdOp_out, wbData_out and memErr_out. stall_out is 0 because memOp_in is 0 from the reset upstream register.
- Reset mid-transaction: the request is abandoned; a late ack after reset release is ignored.
- Non-memory op: 1-cycle latency in to out.
- Memory op: capture edge, then ≥1 WAIT cycle. With ack in the first WAIT cycle, result appears 2 edges after capture, and stall_out is high for exactly 1 cycle.
- dmemReq_out stays high from the capture edge through the ack cycle and falls on the edge after ack; there are never back-to-back requests without an intervening IDLE cycle.
- memErr_out lasts exactly one cycle per offending op.

## Test plan
- Reset: drive rst=0 during WAIT with dmemReq_out=1 -> all outputs 0 immediately; ack=1 one cycle after release -> no writeback, state IDLE.
- ALU passthrough: memOp=0, wdOp=6'b001011, exResult=0x12345678 -> next cycle wdOp_out=0x0B, wbData_out=0x12345678, stall_out=0 throughout.
- Signed byte load: addr 0x00001003, size byte, signed, ack after 3 WAIT cycles, rdata=0x80FFFFFF. Required: dmemAddr_out=0x00001000, be=1000, stall_out high 4 cycles, then wbData_out=0xFFFFFF80.
- Unsigned half load: addr 0x02, rdata=0xBEEF1234 -> wbData_out=0x0000BEEF.
- Half store: addr 0x06, rs2=0xCAFEA55A, immediate ack. Required: dmemWe_out=1, dmemAddr_out=0x04, be=1100, wdata=0xA55AA55A, wdOp_out stays 0.
- Misaligned word load at 0x00000002 -> dmemReq_out stays 0, memErr_out pulses 1 cycle, wdOp_out=0, stall_out=0.
